// File: rtl/testbasic4_reader.sv
// Blocking-handshake integer reader: accumulates BLOCK_LEN signed words and publishes sum/overflow/count.
// Optional macro TESTBASIC4_READER_SAT_EN selects saturating accumulation instead of wrap-around.
module testbasic4_reader #(
  parameter int unsigned BLOCK_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] b_in,
  input  logic               b_in_sync,
  output logic               b_in_notify,
  output logic signed [31:0] sum_out,
  output logic               sum_valid,
  output logic               ovf_out,
  output logic [15:0]        blk_count
);

  localparam logic [1:0] ST_READ    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               notify_q, notify_d;
  logic signed [31:0] acc_q, acc_d;
  logic [15:0]        word_cnt_q, word_cnt_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic signed [31:0] sum_q, sum_d;
  logic               sum_valid_q, sum_valid_d;
  logic               ovf_out_q, ovf_out_d;
  logic [15:0]        blk_count_q, blk_count_d;

  logic signed [31:0] add_sum;
  logic               add_ovf;
  logic [31:0]        next_cnt;
  logic               transfer;

  // Overflow: same-sign operands giving an opposite-sign result.
  function automatic logic add_overflow(input logic signed [31:0] a,
                                        input logic signed [31:0] b,
                                        input logic signed [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  function automatic logic signed [31:0] add_word(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    logic signed [31:0] s;
    s = a + b;
`ifdef TESTBASIC4_READER_SAT_EN
    if (add_overflow(a, b, s)) begin
      s = a[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end
`endif
    return s;
  endfunction

  always_comb begin
    add_sum  = add_word(acc_q, b_in);
    add_ovf  = add_overflow(acc_q, b_in, acc_q + b_in);
    next_cnt = 32'(word_cnt_q) + 32'd1;
    transfer = notify_q && b_in_sync;

    state_d     = state_q;
    notify_d    = notify_q;
    acc_d       = acc_q;
    word_cnt_d  = word_cnt_q;
    ovf_acc_d   = ovf_acc_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    ovf_out_d   = ovf_out_q;
    blk_count_d = blk_count_q;

    case (state_q)
      ST_READ: begin
        if (transfer) begin
          notify_d = 1'b0;
          if (next_cnt < 32'(BLOCK_LEN)) begin
            acc_d      = add_sum;
            word_cnt_d = word_cnt_q + 16'd1;
            ovf_acc_d  = ovf_acc_q | add_ovf;
            state_d    = ST_SETTLE;
          end else begin
            sum_d       = add_sum;
            ovf_out_d   = ovf_acc_q | add_ovf;
            sum_valid_d = 1'b1;
            blk_count_d = blk_count_q + 16'd1;
            acc_d       = '0;
            word_cnt_d  = '0;
            ovf_acc_d   = 1'b0;
            state_d     = ST_PUBLISH;
          end
        end
      end
      ST_SETTLE: begin
        notify_d = 1'b1;
        state_d  = ST_READ;
      end
      ST_PUBLISH: begin
        notify_d = 1'b1;
        state_d  = ST_READ;
      end
      default: begin
        notify_d = 1'b1;
        state_d  = ST_READ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_READ;
      notify_q    <= 1'b1;
      acc_q       <= '0;
      word_cnt_q  <= '0;
      ovf_acc_q   <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      ovf_out_q   <= 1'b0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      notify_q    <= notify_d;
      acc_q       <= acc_d;
      word_cnt_q  <= word_cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      ovf_out_q   <= ovf_out_d;
      blk_count_q <= blk_count_d;
    end
  end

  assign b_in_notify = notify_q;
  assign sum_out     = sum_q;
  assign sum_valid   = sum_valid_q;
  assign ovf_out     = ovf_out_q;
  assign blk_count   = blk_count_q;

endmodule
